// File: rtl/stack_mem_ctrl.sv
// Sequencing controller for a 64-byte big-endian data RAM: turns 16-bit load/store/push/pop
// requests into two byte accesses and owns the full-descending stack pointer.
module stack_mem_ctrl #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int STACK_LIMIT = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReqValid,
    input  logic [1:0]        ReqOp,
    input  logic [15:0]       ReqAddr,
    input  logic [15:0]       ReqData,
    output logic              ReqReady,
    output logic              RespValid,
    output logic [15:0]       RespData,
    output logic              RespErr,
    output logic              RamEn,
    output logic              RamWe,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [7:0]        RamWData,
    input  logic [7:0]        RamRData,
    output logic [15:0]       CurrentSP,
    output logic              StackEmpty,
    output logic              StackFull
);

    localparam logic [15:0]       SP_EMPTY  = 16'(DEPTH);
    localparam logic [15:0]       MAX_ADDR  = 16'(DEPTH - 2);
    localparam logic [15:0]       FULL_THR  = 16'(STACK_LIMIT + 2);
    localparam logic [15:0]       WORD_STEP = 16'd2;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        OP_LOAD   = 2'b00;
    localparam logic [1:0]        OP_STORE  = 2'b01;
    localparam logic [1:0]        OP_PUSH   = 2'b10;
    localparam logic [1:0]        OP_POP    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACC_HI = 3'd1,
        S_ACC_LO = 3'd2,
        S_CAP    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       sp_q, sp_d;
    logic [15:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic [15:0]       sp_dec_s;
    logic [15:0]       sp_inc_s;
    logic              full_s;
    logic              empty_s;
    logic              is_write_s;
    logic              req_err_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic              ram_en_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [7:0]        ram_wdata_s;

    assign sp_dec_s   = sp_q - WORD_STEP;
    assign sp_inc_s   = sp_q + WORD_STEP;
    assign full_s     = (sp_q < FULL_THR);
    assign empty_s    = (sp_q == SP_EMPTY);
    assign is_write_s = (op_q == OP_STORE) || (op_q == OP_PUSH);

    // Request decode: fault check on the full 16-bit values and the word's high-byte address.
    always_comb begin
        req_err_s  = 1'b1;
        req_addr_s = {ADDR_W{1'b0}};
        case (ReqOp)
            OP_LOAD, OP_STORE: begin
                req_err_s  = (ReqAddr > MAX_ADDR);
                req_addr_s = ReqAddr[ADDR_W-1:0];
            end
            OP_PUSH: begin
                req_err_s  = full_s;
                req_addr_s = sp_dec_s[ADDR_W-1:0];
            end
            OP_POP: begin
                req_err_s  = empty_s;
                req_addr_s = sp_q[ADDR_W-1:0];
            end
            default: begin
                req_err_s  = 1'b1;
                req_addr_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Next-state, datapath captures and RAM strobes.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        hi_d        = hi_q;
        sp_d        = sp_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = {ADDR_W{1'b0}};
        ram_wdata_s = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    op_d   = ReqOp;
                    addr_d = req_addr_s;
                    data_d = ReqData;
                    if (req_err_s) begin
                        state_d     = S_RESP;
                        resp_data_d = 16'h0000;
                        resp_err_d  = 1'b1;
                    end else begin
                        state_d = S_ACC_HI;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC_HI: begin
                ram_en_s    = 1'b1;
                ram_we_s    = is_write_s;
                ram_addr_s  = addr_q;
                ram_wdata_s = data_q[15:8];
                state_d     = S_ACC_LO;
            end
            S_ACC_LO: begin
                ram_en_s    = 1'b1;
                ram_we_s    = is_write_s;
                ram_addr_s  = addr_q + ADDR_ONE;
                ram_wdata_s = data_q[7:0];
                // SP moves here so it is already current by the response cycle.
                if (op_q == OP_PUSH) begin
                    sp_d = sp_dec_s;
                end else if (op_q == OP_POP) begin
                    sp_d = sp_inc_s;
                end else begin
                    sp_d = sp_q;
                end
                if (is_write_s) begin
                    state_d     = S_RESP;
                    resp_data_d = 16'h0000;
                    resp_err_d  = 1'b0;
                end else begin
                    hi_d    = RamRData;
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                resp_data_d = {hi_q, RamRData};
                resp_err_d  = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            addr_q      <= {ADDR_W{1'b0}};
            data_q      <= 16'h0000;
            hi_q        <= 8'h00;
            sp_q        <= SP_EMPTY;
            resp_data_q <= 16'h0000;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            hi_q        <= hi_d;
            sp_q        <= sp_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign ReqReady   = (state_q == S_IDLE);
    assign RespValid  = (state_q == S_RESP);
    assign RespData   = resp_data_q;
    assign RespErr    = resp_err_q;
    assign RamEn      = ram_en_s;
    assign RamWe      = ram_we_s;
    assign RamAddr    = ram_addr_s;
    assign RamWData   = ram_wdata_s;
    assign CurrentSP  = sp_q;
    assign StackEmpty = empty_s;
    assign StackFull  = full_s;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl: directed vector table, stack fill/drain, reset
// mid-push, then random requests checked against a word-level stack/memory model.
module tb_stack_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqValid;
    logic [1:0]  ReqOp;
    logic [15:0] ReqAddr;
    logic [15:0] ReqData;
    logic        ReqReady;
    logic        RespValid;
    logic [15:0] RespData;
    logic        RespErr;
    logic        RamEn;
    logic        RamWe;
    logic [5:0]  RamAddr;
    logic [7:0]  RamWData;
    logic [7:0]  ram_rdata;
    logic [15:0] CurrentSP;
    logic        StackEmpty;
    logic        StackFull;

    bit [7:0] ram     [0:63];
    bit [7:0] ref_mem [0:63];
    int       ref_sp;
    int       n_vec;
    int       n_err;

    stack_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .ReqReady(ReqReady), .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr),
        .RamEn(RamEn), .RamWe(RamWe), .RamAddr(RamAddr), .RamWData(RamWData),
        .RamRData(ram_rdata), .CurrentSP(CurrentSP),
        .StackEmpty(StackEmpty), .StackFull(StackFull)
    );

    initial forever #5 clk = ~clk;

    // Single-port synchronous RAM, read data one cycle after the read strobe.
    always @(posedge clk) begin
        if (RamEn) begin
            if (RamWe) ram[RamAddr] <= RamWData;
            else       ram_rdata    <= ram[RamAddr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference: stack as an integer pointer over a byte array.
    task automatic model(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                         output logic e, output logic [15:0] d, output int lat);
        int a;
        e = 1'b0; d = 16'h0000; lat = 1;
        a = int'(addr);
        case (op)
            2'b00: if (a > 62) e = 1'b1;
                   else begin d = {ref_mem[a], ref_mem[a+1]}; lat = 4; end
            2'b01: if (a > 62) e = 1'b1;
                   else begin ref_mem[a] = data[15:8]; ref_mem[a+1] = data[7:0]; lat = 3; end
            2'b10: if (ref_sp < 50) e = 1'b1;
                   else begin
                       ref_sp = ref_sp - 2;
                       ref_mem[ref_sp] = data[15:8]; ref_mem[ref_sp+1] = data[7:0]; lat = 3;
                   end
            default: if (ref_sp == 64) e = 1'b1;
                   else begin
                       d = {ref_mem[ref_sp], ref_mem[ref_sp+1]}; ref_sp = ref_sp + 2; lat = 4;
                   end
        endcase
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                          output logic e, output logic [15:0] d, output int lat, output int ram_cnt);
        int w;
        w = 0; e = 1'b0; d = 16'h0000; lat = 0; ram_cnt = 0;
        @(negedge clk);
        while (!ReqReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqOp = op; ReqAddr = addr; ReqData = data;
        @(posedge clk);
        #1 ReqValid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (RamEn) ram_cnt++;
            if (RespValid) begin
                lat = n; e = RespErr; d = RespData;
                break;
            end
        end
    endtask

    task automatic run_model_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
        logic        e, ee;
        logic [15:0] d, ed;
        int          lat, elat, rc;
        model(op, addr, data, ee, ed, elat);
        do_req(op, addr, data, e, d, lat, rc);
        chk("m_err",   32'(e),   32'(ee));
        chk("m_data",  32'(d),   32'(ed));
        chk("m_lat",   32'(lat), 32'(elat));
        chk("m_ramcnt", 32'(rc), ee ? 32'd0 : 32'd2);
        chk("m_sp",    32'(CurrentSP),  32'(ref_sp));
        chk("m_empty", 32'(StackEmpty), 32'(ref_sp == 64));
        chk("m_full",  32'(StackFull),  32'(ref_sp < 50));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_err;
        logic [15:0] exp_data;
        int          exp_lat;
        int          exp_sp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic        e, me;
        logic [15:0] d, md;
        int          lat, mlat, rc;

        n_vec = 0; n_err = 0; ref_sp = 64;
        tbl[0]  = '{2'b01, 16'h0010, 16'hA55A, 1'b0, 16'h0000, 3, 64};
        tbl[1]  = '{2'b00, 16'h0010, 16'h0000, 1'b0, 16'hA55A, 4, 64};
        tbl[2]  = '{2'b10, 16'h0000, 16'h1234, 1'b0, 16'h0000, 3, 62};
        tbl[3]  = '{2'b10, 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 3, 60};
        tbl[4]  = '{2'b11, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 4, 62};
        tbl[5]  = '{2'b11, 16'h0000, 16'h0000, 1'b0, 16'h1234, 4, 64};
        tbl[6]  = '{2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1, 64};
        tbl[7]  = '{2'b00, 16'h003F, 16'h0000, 1'b1, 16'h0000, 1, 64};
        tbl[8]  = '{2'b01, 16'h0100, 16'h9999, 1'b1, 16'h0000, 1, 64};
        tbl[9]  = '{2'b00, 16'h003E, 16'h0000, 1'b0, 16'h1234, 4, 64};
        tbl[10] = '{2'b01, 16'h0021, 16'hC3D2, 1'b0, 16'h0000, 3, 64};
        tbl[11] = '{2'b00, 16'h0021, 16'h0000, 1'b0, 16'hC3D2, 4, 64};
        tbl[12] = '{2'b00, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 64};

        rst_n = 1'b0; ReqValid = 1'b0; ReqOp = 2'b00; ReqAddr = 16'h0000; ReqData = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ReqReady),   32'd1);
        chk("rst_rvld",  32'(RespValid),  32'd0);
        chk("rst_rdata", 32'(RespData),   32'd0);
        chk("rst_rerr",  32'(RespErr),    32'd0);
        chk("rst_ramen", 32'(RamEn),      32'd0);
        chk("rst_ramwe", 32'(RamWe),      32'd0);
        chk("rst_raddr", 32'(RamAddr),    32'd0);
        chk("rst_wdata", 32'(RamWData),   32'd0);
        chk("rst_sp",    32'(CurrentSP),  32'd64);
        chk("rst_empty", 32'(StackEmpty), 32'd1);
        chk("rst_full",  32'(StackFull),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            model(tbl[i].op, tbl[i].addr, tbl[i].data, me, md, mlat);
            do_req(tbl[i].op, tbl[i].addr, tbl[i].data, e, d, lat, rc);
            chk("t_err",    32'(e),   32'(tbl[i].exp_err));
            chk("t_data",   32'(d),   32'(tbl[i].exp_data));
            chk("t_lat",    32'(lat), 32'(tbl[i].exp_lat));
            chk("t_ramcnt", 32'(rc),  tbl[i].exp_err ? 32'd0 : 32'd2);
            chk("t_sp",     32'(CurrentSP),  32'(tbl[i].exp_sp));
            chk("t_empty",  32'(StackEmpty), 32'(tbl[i].exp_sp == 64));
        end
        chk("ram10", 32'(ram[16]), 32'hA5);
        chk("ram11", 32'(ram[17]), 32'h5A);

        for (int i = 0; i < 9; i++) run_model_req(2'b10, 16'h0000, 16'(16'h1000 + i * 273));
        chk("full_sp",   32'(CurrentSP), 32'd48);
        chk("full_flag", 32'(StackFull), 32'd1);
        for (int i = 0; i < 8; i++) run_model_req(2'b11, 16'h0000, 16'h0000);

        run_model_req(2'b10, 16'h0000, 16'h5555);
        @(negedge clk);
        ReqValid = 1'b1; ReqOp = 2'b10; ReqAddr = 16'h0000; ReqData = 16'hCAFE;
        @(posedge clk);
        #1 ReqValid = 1'b0;
        @(negedge clk);
        chk("mr_hi_en",   32'(RamEn),    32'd1);
        chk("mr_hi_we",   32'(RamWe),    32'd1);
        chk("mr_hi_addr", 32'(RamAddr),  32'd60);
        chk("mr_hi_data", 32'(RamWData), 32'hCA);
        @(negedge clk);
        chk("mr_lo_en",   32'(RamEn),    32'd1);
        chk("mr_lo_addr", 32'(RamAddr),  32'd61);
        chk("mr_lo_data", 32'(RamWData), 32'hFE);
        rst_n = 1'b0;
        #1;
        chk("mr_en_drop", 32'(RamEn),     32'd0);
        chk("mr_sp",      32'(CurrentSP), 32'd64);
        ref_mem[60] = 8'hCA;
        ref_sp = 64;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_resp", 32'(RespValid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_ready", 32'(ReqReady), 32'd1);
        run_model_req(2'b10, 16'h0000, 16'h7777);
        chk("mr_next_sp", 32'(CurrentSP), 32'd62);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  op;
            logic [15:0] a;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 64)) : 16'($urandom);
            run_model_req(op, a, 16'($urandom));
        end

        for (int i = 0; i < 64; i++) chk("mem", 32'(ram[i]), 32'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
